// File: rtl/reg_file_pkg.sv
// Shared constants, FSM state encodings and helpers for the multi-read-port register file.
package reg_file_pkg;

    localparam int RF_WIDTH      = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_MAX_RD     = 4;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_INIT = ST_INIT,
        S_RUN  = ST_RUN
    } rf_state_e;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback-side bus of the register file: one write port, NUM_RD packed read ports.
interface reg_file_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         we;
    logic [ADDR_WIDTH-1:0]        w_addr;
    logic [WIDTH-1:0]             w_data;
    logic [NUM_RD-1:0]            r_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] r_addr;
    logic [NUM_RD*WIDTH-1:0]      r_data;
    logic                         init_busy;

    modport master (
        output we, w_addr, w_data, r_en, r_addr,
        input  r_data, init_busy
    );

    modport slave (
        input  we, w_addr, w_data, r_en, r_addr,
        output r_data, init_busy
    );
endinterface

// File: rtl/reg_file_init_fsm.sv
// INIT/RUN controller: sweeps zeros through the array after reset, then passes the external
// write port through (dropping x0 writes when ZERO_REG=1 and any write coinciding with rst).
module reg_file_init_fsm
    import reg_file_pkg::*;
#(
    parameter int WIDTH      = RF_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_w_addr,
    input  logic [WIDTH-1:0]      i_w_data,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [WIDTH-1:0]      o_w_data,
    output logic                  o_init_busy
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    rf_state_e             r_state;
    rf_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_we        = 1'b0;
        o_w_addr    = i_w_addr;
        o_w_data    = i_w_data;
        o_init_busy = 1'b0;
        case (r_state)
            S_INIT: begin
                o_init_busy = 1'b1;
                o_we        = !rst;
                o_w_addr    = r_cnt;
                o_w_data    = '0;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_we = i_we && !rst && !(ZERO_REG && (i_w_addr == '0));
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port RV32 register file: one RAM bank per read port, 1-cycle registered reads.
// Define REG_FILE_BYPASS_EN for write-first collisions; otherwise reads are read-first.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int WIDTH      = RF_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [WIDTH-1:0]      w_wdata;
    logic                  w_init_busy;

    reg_file_init_fsm #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_init_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_we        (bus.we),
        .i_w_addr    (bus.w_addr),
        .i_w_data    (bus.w_data),
        .o_we        (w_we),
        .o_w_addr    (w_waddr),
        .o_w_data    (w_wdata),
        .o_init_busy (w_init_busy)
    );

    assign bus.init_busy = w_init_busy;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_bank
        logic [WIDTH-1:0]      r_mem [DEPTH];
        logic [WIDTH-1:0]      r_q;
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic                  w_zero_hit;

        assign w_raddr    = bus.r_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_zero_hit = ZERO_REG && (w_raddr == '0);

        // NOTE: the array has no reset so it maps onto RAM; only the INIT sweep clears it.
        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_waddr] <= w_wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (bus.r_en[g]) begin
                if (w_init_busy || w_zero_hit) begin
                    r_q <= '0;
                end else begin
                    r_q <= r_mem[w_raddr];
                end
            end
        end

`ifdef REG_FILE_BYPASS_EN
        logic             r_hit;
        logic [WIDTH-1:0] r_fwd;

        // Collision is resolved after the RAM output register, keeping the RAM read path clean.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_hit <= 1'b0;
                r_fwd <= '0;
            end else if (bus.r_en[g]) begin
                r_hit <= w_we && !w_init_busy && !w_zero_hit && (w_waddr == w_raddr);
                r_fwd <= w_wdata;
            end
        end

        assign bus.r_data[g*WIDTH +: WIDTH] = r_hit ? r_fwd : r_q;
`else
        assign bus.r_data[g*WIDTH +: WIDTH] = r_q;
`endif
    end

endmodule
